// File: rtl/riscv_v_pkg.sv
// Shared constants and entry layout for the vector write-back pipeline.
package riscv_v_pkg;

    localparam int unsigned RISCV_V_DATA_W        = 128;
    localparam int unsigned RISCV_V_NUM_BYTES     = RISCV_V_DATA_W / 8;
    localparam int unsigned RISCV_V_ADDR_W        = 5;
    localparam int unsigned RISCV_V_WB_NUM_STAGES = 2;
    localparam int unsigned RISCV_V_NUM_RD_PORTS  = 3;

    // Default-width layout of one in-flight register-file write.
    typedef struct packed {
        logic                         valid;
        logic [RISCV_V_ADDR_W-1:0]    addr;
        logic [RISCV_V_NUM_BYTES-1:0] en;
        logic [RISCV_V_DATA_W-1:0]    data;
    } riscv_v_wb_entry_t;

endpackage

// File: rtl/riscv_v_wb_pipe_if.sv
// Bus between EXE/ID/RF and the vector write-back pipeline.
// Optional perf counter signals exist only with RISCV_V_WB_PIPE_PERF_CNT_EN.
interface riscv_v_wb_pipe_if
    import riscv_v_pkg::*;
#(
    parameter int unsigned DATA_W       = RISCV_V_DATA_W,
    parameter int unsigned NUM_BYTES    = DATA_W / 8,
    parameter int unsigned ADDR_W       = RISCV_V_ADDR_W,
    parameter int unsigned NUM_RD_PORTS = RISCV_V_NUM_RD_PORTS
);
    logic                             stall;
    logic                             flush;
    logic                             exe_valid;
    logic                             exe_late;
    logic [ADDR_W-1:0]                exe_wr_addr;
    logic [NUM_BYTES-1:0]             exe_wr_en;
    logic [DATA_W-1:0]                exe_wr_data;
    logic [NUM_RD_PORTS-1:0]          id_rd_valid;
    logic [NUM_RD_PORTS*ADDR_W-1:0]   id_rd_addr;
    logic [NUM_RD_PORTS*DATA_W-1:0]   rf_rd_data;
    logic [NUM_RD_PORTS*DATA_W-1:0]   id_rd_data;
    logic                             hazard_stall;
    logic [NUM_BYTES-1:0]             wb_wr_en;
    logic [ADDR_W-1:0]                wb_wr_addr;
    logic [DATA_W-1:0]                wb_wr_data;
`ifdef RISCV_V_WB_PIPE_PERF_CNT_EN
    logic [31:0]                      perf_fwd_cnt;
    logic [31:0]                      perf_hazard_cnt;
`endif

    modport master (
        output stall, flush, exe_valid, exe_late, exe_wr_addr, exe_wr_en, exe_wr_data,
        output id_rd_valid, id_rd_addr, rf_rd_data,
`ifdef RISCV_V_WB_PIPE_PERF_CNT_EN
        input  perf_fwd_cnt, perf_hazard_cnt,
`endif
        input  id_rd_data, hazard_stall, wb_wr_en, wb_wr_addr, wb_wr_data
    );

    modport slave (
        input  stall, flush, exe_valid, exe_late, exe_wr_addr, exe_wr_en, exe_wr_data,
        input  id_rd_valid, id_rd_addr, rf_rd_data,
`ifdef RISCV_V_WB_PIPE_PERF_CNT_EN
        output perf_fwd_cnt, perf_hazard_cnt,
`endif
        output id_rd_data, hazard_stall, wb_wr_en, wb_wr_addr, wb_wr_data
    );

endinterface

// File: rtl/riscv_v_byte_fwd_mux.sv
// Per-byte forwarding select for one ID read port.
// Candidate 0 is the youngest (EXE); higher indices are progressively older.
module riscv_v_byte_fwd_mux
    import riscv_v_pkg::*;
#(
    parameter int unsigned DATA_W   = RISCV_V_DATA_W,
    parameter int unsigned ADDR_W   = RISCV_V_ADDR_W,
    parameter int unsigned NUM_CAND = RISCV_V_WB_NUM_STAGES + 1
) (
    input  logic [NUM_CAND-1:0]            cand_valid,
    input  logic [NUM_CAND*ADDR_W-1:0]     cand_addr,
    input  logic [NUM_CAND*(DATA_W/8)-1:0] cand_en,
    input  logic [NUM_CAND*DATA_W-1:0]     cand_data,
    input  logic                           rd_valid,
    input  logic [ADDR_W-1:0]              rd_addr,
    input  logic [DATA_W-1:0]              rf_data,
`ifdef RISCV_V_WB_PIPE_PERF_CNT_EN
    output logic                           fwd_hit,
`endif
    output logic [DATA_W-1:0]              rd_data
);
    localparam int unsigned NUM_BYTES = DATA_W / 8;

    // Walk oldest to youngest so the youngest matching source overrides each byte.
    always_comb begin
        rd_data = rf_data;
`ifdef RISCV_V_WB_PIPE_PERF_CNT_EN
        fwd_hit = 1'b0;
`endif
        if (rd_valid) begin
            for (int b = 0; b < NUM_BYTES; b++) begin
                for (int c = NUM_CAND - 1; c >= 0; c--) begin
                    if (cand_valid[c] && cand_addr[c*ADDR_W +: ADDR_W] == rd_addr &&
                        cand_en[c*NUM_BYTES + b]) begin
                        rd_data[b*8 +: 8] = cand_data[c*DATA_W + b*8 +: 8];
`ifdef RISCV_V_WB_PIPE_PERF_CNT_EN
                        fwd_hit = 1'b1;
`endif
                    end
                end
            end
        end
    end

endmodule

// File: rtl/riscv_v_wb_pipe.sv
// Vector write-back pipeline: EXE -> stage 1 .. stage NUM_STAGES (WB) -> RF write port,
// with per-byte forwarding to the ID read ports and a late-result RAW stall.
// Macro RISCV_V_WB_PIPE_PERF_CNT_EN adds forwarding / hazard event counters.
module riscv_v_wb_pipe
    import riscv_v_pkg::*;
#(
    parameter int unsigned DATA_W       = RISCV_V_DATA_W,
    parameter int unsigned NUM_BYTES    = DATA_W / 8,
    parameter int unsigned ADDR_W       = RISCV_V_ADDR_W,
    parameter int unsigned NUM_STAGES   = RISCV_V_WB_NUM_STAGES,
    parameter int unsigned NUM_RD_PORTS = RISCV_V_NUM_RD_PORTS
) (
    input  logic            clk,
    input  logic            rst,
    riscv_v_wb_pipe_if.slave bus
);
    localparam int unsigned NUM_CAND = NUM_STAGES + 1;

    typedef struct packed {
        logic                 valid;
        logic [ADDR_W-1:0]    addr;
        logic [NUM_BYTES-1:0] en;
        logic [DATA_W-1:0]    data;
    } entry_t;

    entry_t stage_q [NUM_STAGES];

    logic                          exe_fire;
    logic [NUM_CAND-1:0]           cand_valid;
    logic [NUM_CAND*ADDR_W-1:0]    cand_addr;
    logic [NUM_CAND*NUM_BYTES-1:0] cand_en;
    logic [NUM_CAND*DATA_W-1:0]    cand_data;
    logic [NUM_RD_PORTS*DATA_W-1:0] rd_data;

    assign exe_fire = bus.exe_valid & ~bus.flush & ~bus.exe_late;

    // Shift chain; stall freezes every stage and masks flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                stage_q[k] <= '0;
            end
        end else if (!bus.stall) begin
            stage_q[0].valid <= exe_fire;
            stage_q[0].addr  <= bus.exe_wr_addr;
            stage_q[0].en    <= bus.flush ? '0 : bus.exe_wr_en;
            stage_q[0].data  <= bus.exe_wr_data;
            for (int k = 1; k < NUM_STAGES; k++) begin
                stage_q[k] <= stage_q[k-1];
            end
        end
    end

    assign bus.wb_wr_en   = stage_q[NUM_STAGES-1].valid ? stage_q[NUM_STAGES-1].en : '0;
    assign bus.wb_wr_addr = stage_q[NUM_STAGES-1].addr;
    assign bus.wb_wr_data = stage_q[NUM_STAGES-1].data;

    // Flatten forwarding sources, youngest (EXE) at index 0.
    always_comb begin
        cand_valid = '0;
        cand_addr  = '0;
        cand_en    = '0;
        cand_data  = '0;
        cand_valid[0]               = exe_fire;
        cand_addr[0 +: ADDR_W]      = bus.exe_wr_addr;
        cand_en[0 +: NUM_BYTES]     = bus.exe_wr_en;
        cand_data[0 +: DATA_W]      = bus.exe_wr_data;
        for (int k = 0; k < NUM_STAGES; k++) begin
            cand_valid[k+1]                    = stage_q[k].valid;
            cand_addr[(k+1)*ADDR_W +: ADDR_W]  = stage_q[k].addr;
            cand_en[(k+1)*NUM_BYTES +: NUM_BYTES] = stage_q[k].en;
            cand_data[(k+1)*DATA_W +: DATA_W]  = stage_q[k].data;
        end
    end

`ifdef RISCV_V_WB_PIPE_PERF_CNT_EN
    logic [NUM_RD_PORTS-1:0] fwd_hit;
`endif

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
        riscv_v_byte_fwd_mux #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .NUM_CAND (NUM_CAND)
        ) u_fwd_mux (
            .cand_valid (cand_valid),
            .cand_addr  (cand_addr),
            .cand_en    (cand_en),
            .cand_data  (cand_data),
            .rd_valid   (bus.id_rd_valid[p]),
            .rd_addr    (bus.id_rd_addr[p*ADDR_W +: ADDR_W]),
            .rf_data    (bus.rf_rd_data[p*DATA_W +: DATA_W]),
`ifdef RISCV_V_WB_PIPE_PERF_CNT_EN
            .fwd_hit    (fwd_hit[p]),
`endif
            .rd_data    (rd_data[p*DATA_W +: DATA_W])
        );
    end

    assign bus.id_rd_data = rd_data;

    // A late EXE result that ID wants to read cannot be forwarded yet.
    always_comb begin
        bus.hazard_stall = 1'b0;
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            if (bus.id_rd_valid[p] && bus.exe_valid && bus.exe_late && !bus.flush &&
                bus.exe_wr_addr == bus.id_rd_addr[p*ADDR_W +: ADDR_W] && |bus.exe_wr_en) begin
                bus.hazard_stall = 1'b1;
            end
        end
    end

`ifdef RISCV_V_WB_PIPE_PERF_CNT_EN
    logic [31:0] perf_fwd_q;
    logic [31:0] perf_hazard_q;

    // Event counters; natural wrap at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fwd_q    <= '0;
            perf_hazard_q <= '0;
        end else begin
            if (|fwd_hit) begin
                perf_fwd_q <= perf_fwd_q + 32'd1;
            end
            if (bus.hazard_stall) begin
                perf_hazard_q <= perf_hazard_q + 32'd1;
            end
        end
    end

    assign bus.perf_fwd_cnt    = perf_fwd_q;
    assign bus.perf_hazard_cnt = perf_hazard_q;
`endif

endmodule

// File: tb/tb_riscv_v_wb_pipe.sv
// Directed self-checking bench for riscv_v_wb_pipe (default parameters).
module tb_riscv_v_wb_pipe;
    import riscv_v_pkg::*;

    localparam int unsigned DW = 128;
    localparam int unsigned AW = 5;
    localparam int unsigned NP = 3;

    logic clk;
    logic rst;

    int checks = 0;
    int errors = 0;

    riscv_v_wb_pipe_if #(
        .DATA_W       (DW),
        .ADDR_W       (AW),
        .NUM_RD_PORTS (NP)
    ) bus_if ();

    riscv_v_wb_pipe #(
        .DATA_W       (DW),
        .ADDR_W       (AW),
        .NUM_STAGES   (2),
        .NUM_RD_PORTS (NP)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [DW-1:0] RF = {16{8'h33}};

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exe(input logic v, input logic late, input logic [AW-1:0] a,
                       input logic [15:0] en, input logic [7:0] byte_val);
        bus_if.exe_valid   = v;
        bus_if.exe_late    = late;
        bus_if.exe_wr_addr = a;
        bus_if.exe_wr_en   = en;
        bus_if.exe_wr_data = {16{byte_val}};
    endtask

    task automatic rd(input int p, input logic v, input logic [AW-1:0] a);
        bus_if.id_rd_valid[p]       = v;
        bus_if.id_rd_addr[p*AW +: AW] = a;
    endtask

    function automatic logic [DW-1:0] port_data(input int p);
        return bus_if.id_rd_data[p*DW +: DW];
    endfunction

    initial begin
        rst = 1'b1;
        bus_if.stall = 1'b0;
        bus_if.flush = 1'b0;
        exe(1'b0, 1'b0, 5'd0, 16'h0, 8'h00);
        bus_if.id_rd_valid = '0;
        bus_if.id_rd_addr  = '0;
        bus_if.rf_rd_data  = {NP{RF}};
        rd(0, 1'b1, 5'd0);
        #1;
        check("rst_wb_en", {112'd0, bus_if.wb_wr_en}, '0);
        check("rst_wb_addr", {123'd0, bus_if.wb_wr_addr}, '0);
        check("rst_wb_data", bus_if.wb_wr_data, '0);
        check("rst_hazard", {127'd0, bus_if.hazard_stall}, '0);
        check("rst_rd_v0", port_data(0), RF);
        rd(0, 1'b0, 5'd0);
        #11 rst = 1'b0;
        tick();

        // Latency
        exe(1'b1, 1'b0, 5'd3, 16'hFFFF, 8'hA5);
        #1 check("lat_before0", {112'd0, bus_if.wb_wr_en}, '0);
        tick();
        exe(1'b0, 1'b0, 5'd0, 16'h0, 8'h00);
        #1 check("lat_before1", {112'd0, bus_if.wb_wr_en}, '0);
        tick();
        check("lat_wb_en", {112'd0, bus_if.wb_wr_en}, {112'd0, 16'hFFFF});
        check("lat_wb_addr", {123'd0, bus_if.wb_wr_addr}, 128'd3);
        check("lat_wb_data", bus_if.wb_wr_data, {16{8'hA5}});
        tick();
        check("lat_after", {112'd0, bus_if.wb_wr_en}, '0);

        // Byte merge: stage 2 v5 all 0x11, stage 1 v5 low 4 bytes 0x22
        exe(1'b1, 1'b0, 5'd5, 16'hFFFF, 8'h11);
        tick();
        exe(1'b1, 1'b0, 5'd5, 16'h000F, 8'h22);
        tick();
        exe(1'b0, 1'b0, 5'd0, 16'h0, 8'h00);
        rd(0, 1'b1, 5'd5);
        rd(1, 1'b0, 5'd5);
        rd(2, 1'b1, 5'd6);
        #1;
        check("merge_p0", port_data(0), {{12{8'h11}}, {4{8'h22}}});
        check("merge_unused_p1", port_data(1), RF);
        check("merge_other_p2", port_data(2), RF);

        // Youngest wins: stage 1 v7=0xAA, EXE v7=0xBB
        exe(1'b1, 1'b0, 5'd7, 16'hFFFF, 8'hAA);
        tick();
        exe(1'b1, 1'b0, 5'd7, 16'hFFFF, 8'hBB);
        for (int p = 0; p < NP; p++) rd(p, 1'b1, 5'd7);
        #1;
        for (int p = 0; p < NP; p++) check($sformatf("young_p%0d", p), port_data(p), {16{8'hBB}});
        // Late EXE is not a source; stage 1 supplies the data and ID stalls
        bus_if.exe_late = 1'b1;
        #1;
        check("late_fwd_p0", port_data(0), {16{8'hAA}});
        check("late_hazard_v7", {127'd0, bus_if.hazard_stall}, 128'd1);
        exe(1'b0, 1'b0, 5'd0, 16'h0, 8'h00);
        for (int p = 0; p < NP; p++) rd(p, 1'b0, 5'd0);
        tick();
        tick();

        // Hazard on v9, port 1
        exe(1'b1, 1'b1, 5'd9, 16'hFFFF, 8'h99);
        rd(1, 1'b1, 5'd9);
        #1 check("haz_h0", {127'd0, bus_if.hazard_stall}, 128'd1);
        tick();
        check("haz_h1", {127'd0, bus_if.hazard_stall}, 128'd1);
        check("haz_bubble_rd", port_data(1), RF);
        tick();
        check("haz_bubble_wb", {112'd0, bus_if.wb_wr_en}, '0);
        bus_if.exe_late = 1'b0;
        #1;
        check("haz_clear", {127'd0, bus_if.hazard_stall}, '0);
        check("haz_fwd_exe", port_data(1), {16{8'h99}});
        tick();
        exe(1'b0, 1'b0, 5'd0, 16'h0, 8'h00);
        #1 check("haz_fwd_s1", port_data(1), {16{8'h99}});
        tick();
        check("haz_wb_addr", {123'd0, bus_if.wb_wr_addr}, 128'd9);
        check("haz_wb_en", {112'd0, bus_if.wb_wr_en}, {112'd0, 16'hFFFF});
        rd(1, 1'b0, 5'd0);

        // Stall + flush hold everything
        exe(1'b1, 1'b0, 5'd10, 16'hFFFF, 8'hCC);
        tick();
        exe(1'b1, 1'b0, 5'd11, 16'hFFFF, 8'hDD);
        tick();
        exe(1'b1, 1'b0, 5'd12, 16'hFFFF, 8'hEE);
        bus_if.stall = 1'b1;
        bus_if.flush = 1'b1;
        rd(0, 1'b1, 5'd11);
        rd(2, 1'b1, 5'd12);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("sf_wb_addr%0d", i), {123'd0, bus_if.wb_wr_addr}, 128'd10);
            check($sformatf("sf_wb_data%0d", i), bus_if.wb_wr_data, {16{8'hCC}});
            check($sformatf("sf_s1_%0d", i), port_data(0), {16{8'hDD}});
            check($sformatf("sf_exe_%0d", i), port_data(2), RF);
        end
        bus_if.stall = 1'b0;
        tick();
        check("fl_wb_addr", {123'd0, bus_if.wb_wr_addr}, 128'd11);
        check("fl_wb_data", bus_if.wb_wr_data, {16{8'hDD}});
        bus_if.flush = 1'b0;
        exe(1'b0, 1'b0, 5'd0, 16'h0, 8'h00);
        rd(0, 1'b1, 5'd12);
        #1 check("fl_s1_bubble", port_data(0), RF);
        tick();
        check("fl_wb_bubble", {112'd0, bus_if.wb_wr_en}, '0);
        rd(0, 1'b0, 5'd0);
        rd(2, 1'b0, 5'd0);

        // Asynchronous reset with two writes in flight
        exe(1'b1, 1'b0, 5'd13, 16'hFFFF, 8'h13);
        tick();
        exe(1'b1, 1'b0, 5'd14, 16'hFFFF, 8'h14);
        tick();
        exe(1'b0, 1'b0, 5'd0, 16'h0, 8'h00);
        rd(0, 1'b1, 5'd14);
        #1 check("ar_pre_wb_en", {112'd0, bus_if.wb_wr_en}, {112'd0, 16'hFFFF});
        #2 rst = 1'b1;
        #1 check("ar_wb_en", {112'd0, bus_if.wb_wr_en}, '0);
        check("ar_s1_gone", port_data(0), RF);
        @(posedge clk);
        #3 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("ar_drain%0d", i), {112'd0, bus_if.wb_wr_en}, '0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
